// File: rtl/audio_pkg.sv
// Shared constants and the stereo sample-pair type for the I2S transmit path.
package audio_pkg;
  localparam int CLK_DIV    = 4;
  localparam int SLOT_BITS  = 32;
  localparam int SAMPLE_W   = 16;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;
endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous FIFO of stereo pairs; full is registered so the
// upstream ready never depends on a same-cycle pop.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  stereo_t data_i,
  input  logic    pop_i,
  output stereo_t data_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  stereo_t        mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           full_q, full_d;
  logic           do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign full_d = (count_d == CW'(DEPTH));

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: SCLK divider, frame bit counter and left/right serializer
// fed from a stereo-pair FIFO, all in the audio clock domain.
module audio_i2s_tx
  import audio_pkg::stereo_t;
#(
  parameter int CLK_DIV    = audio_pkg::CLK_DIV,
  parameter int SLOT_BITS  = audio_pkg::SLOT_BITS,
  parameter int FIFO_DEPTH = audio_pkg::FIFO_DEPTH
) (
  input  logic                          clk_audio,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [audio_pkg::SAMPLE_W-1:0] s_left,
  input  logic [audio_pkg::SAMPLE_W-1:0] s_right,
  output logic                          audio_sclk,
  output logic                          audio_lrck,
  output logic                          audio_dac,
  output logic                          underrun,
  output logic [7:0]                    underrun_count
);
  localparam int SW    = audio_pkg::SAMPLE_W;
  localparam int FRAME = 2 * SLOT_BITS;
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int B_W   = $clog2(FRAME);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME - 1);
  localparam logic [B_W-1:0]   B_SLOT   = B_W'(SLOT_BITS);
  localparam logic [B_W-1:0]   L_FIRST  = B_W'(1);
  localparam logic [B_W-1:0]   L_LAST   = B_W'(SW);
  localparam logic [B_W-1:0]   R_FIRST  = B_W'(SLOT_BITS + 1);
  localparam logic [B_W-1:0]   R_LAST   = B_W'(SLOT_BITS + SW);

  logic [DIV_W-1:0] div_q, div_d;
  logic [B_W-1:0]   b_q, b_d;
  logic             sclk_q, sclk_d;
  logic             lrck_q, lrck_d;
  logic             dac_q, dac_d;
  logic             und_q, und_d;
  logic [7:0]       und_cnt_q, und_cnt_d;
  logic [SW-1:0]    lsr_q, lsr_d, rsr_q, rsr_d;

  logic    tick, frame_start, in_left, in_right;
  logic    fifo_pop, fifo_full, fifo_empty;
  stereo_t fifo_head, push_pair;

  assign push_pair.left  = s_left;
  assign push_pair.right = s_right;

  audio_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_audio),
    .rst_ni  (reset_n),
    .push_i  (s_valid),
    .data_i  (push_pair),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Bit counter resets to the last slot so the first edge out of reset
  // is a frame start.
  assign tick        = (div_q == '0);
  assign frame_start = tick && (b_q == B_LAST);
  assign fifo_pop    = frame_start && enable && !fifo_empty;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    b_d   = b_q;
    if (tick) b_d = (b_q == B_LAST) ? '0 : b_q + 1'b1;
  end

  // SCLK is registered from the current divider phase, so it falls on the
  // same edge that advances the bit counter.
  assign sclk_d   = (div_q >= DIV_HALF);
  assign in_left  = (b_d >= L_FIRST) && (b_d <= L_LAST);
  assign in_right = (b_d >= R_FIRST) && (b_d <= R_LAST);

  always_comb begin
    lrck_d    = lrck_q;
    dac_d     = dac_q;
    lsr_d     = lsr_q;
    rsr_d     = rsr_q;
    und_d     = 1'b0;
    und_cnt_d = und_cnt_q;
    if (frame_start) begin
      lrck_d = 1'b0;
      dac_d  = 1'b0;
      lsr_d  = fifo_pop ? fifo_head.left  : '0;
      rsr_d  = fifo_pop ? fifo_head.right : '0;
      if (enable && fifo_empty) begin
        und_d = 1'b1;
        if (und_cnt_q != 8'hFF) und_cnt_d = und_cnt_q + 8'd1;
      end
    end else if (tick) begin
      lrck_d = (b_d >= B_SLOT);
      if (in_left) begin
        dac_d = lsr_q[SW-1];
        lsr_d = lsr_q << 1;
      end else if (in_right) begin
        dac_d = rsr_q[SW-1];
        rsr_d = rsr_q << 1;
      end else begin
        dac_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      div_q     <= '0;
      b_q       <= B_LAST;
      sclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      dac_q     <= 1'b0;
      und_q     <= 1'b0;
      und_cnt_q <= '0;
      lsr_q     <= '0;
      rsr_q     <= '0;
    end else begin
      div_q     <= div_d;
      b_q       <= b_d;
      sclk_q    <= sclk_d;
      lrck_q    <= lrck_d;
      dac_q     <= dac_d;
      und_q     <= und_d;
      und_cnt_q <= und_cnt_d;
      lsr_q     <= lsr_d;
      rsr_q     <= rsr_d;
    end
  end

  assign s_ready        = !fifo_full;
  assign audio_sclk     = sclk_q;
  assign audio_lrck     = lrck_q;
  assign audio_dac      = dac_q;
  assign underrun       = und_q;
  assign underrun_count = und_cnt_q;
endmodule
